// File: rtl/matrix_win3x3_gen.sv
// -----------------------------------------------------------------------------
// matrix_win3x3_gen
//
// Streaming 3x3 window generator. Pops pixels from an upstream prefetch FIFO
// (rd_en / rd_vld handshake), keeps the two previous image rows in two line
// buffers and emits one window for every pixel that completes a full 3x3
// neighbourhood (valid-only, no padding).
//
// Ports
//   clk        in   single clock (FIFO read clock)
//   rst        in   synchronous, active-high reset
//   pix_vld    in   FIFO rd_vld: pix_data holds a valid pixel
//   pix_data   in   FIFO rd_data, DATA_WIDTH bits
//   pix_rd_en  out  FIFO rd_en: pops the current pixel (combinational)
//   win_vld    out  window valid
//   win_rdy    in   downstream ready
//   win_data   out  9*DATA_WIDTH window; pixel (r,c) sits at
//                   [DATA_WIDTH*(3r+c) +: DATA_WIDTH], r=0 oldest row,
//                   c=0 oldest column, (2,2) newest pixel
//   win_sof    out  first window of a frame   (only with MATRIX_WIN_FLAGS_EN)
//   win_eol    out  last window of a row      (only with MATRIX_WIN_FLAGS_EN)
//
// Configuration macro
//   MATRIX_WIN_FLAGS_EN : when defined, adds win_sof / win_eol, aligned with
//                         win_vld and held during a stall.
//
// Pipeline
//   cycle N   : pixel accepted, line buffers read (read-before-write)
//   cycle N+1 : stage-1 column {row-2, row-1, row} presented to the window
//               builder together with the two previously shifted columns
//   cycle N+2 : window register drives win_data / win_vld
// A stall (win_vld & ~win_rdy) freezes every register, counter and RAM.
// -----------------------------------------------------------------------------
module matrix_win3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 416,
    parameter int IMG_HEIGHT = 416
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_vld,
    input  logic [DATA_WIDTH-1:0]   pix_data,
    output logic                    pix_rd_en,
    output logic                    win_vld,
    input  logic                    win_rdy,
    output logic [9*DATA_WIDTH-1:0] win_data
`ifdef MATRIX_WIN_FLAGS_EN
    ,
    output logic                    win_sof,
    output logic                    win_eol
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int CV_W  = 3 * DATA_WIDTH;   // one column: {row, row-1, row-2}

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic w_stall;
    logic w_accept;

    assign w_stall   = win_vld & ~win_rdy;
    assign w_accept  = pix_vld & ~w_stall;
    assign pix_rd_en = w_accept;

    // -------------------------------------------------------------------------
    // Position counters (advance on accept only)
    // -------------------------------------------------------------------------
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_emit;

    assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
    // Windows only for pixels that close a full neighbourhood; this also hides
    // the stale columns left in the shift register across a row boundary.
    assign w_emit     = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

`ifdef MATRIX_WIN_FLAGS_EN
    logic w_sof;
    logic w_eol;

    assign w_sof = (r_row == ROW_W'(2)) && (r_col == COL_W'(2));
    assign w_eol = w_col_last;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would chain stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers (read-before-write) and stage-1 data registers
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];   // holds row-1
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];   // holds row-2
    logic [DATA_WIDTH-1:0] r_lb1_q;
    logic [DATA_WIDTH-1:0] r_lb2_q;
    logic [DATA_WIDTH-1:0] r_s1_pix;

    // NOTE: the RAMs and their read registers carry no reset so they map onto
    // block/distributed RAM; stale contents only ever feed suppressed windows.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1_q      <= r_lb1[r_col];
            r_lb2_q      <= r_lb2[r_col];
            r_s1_pix     <= pix_data;
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= pix_data;
        end
    end

    // -------------------------------------------------------------------------
    // Stage-1 control
    // -------------------------------------------------------------------------
    logic r_s1_vld;
    logic r_s1_emit;
`ifdef MATRIX_WIN_FLAGS_EN
    logic r_s1_sof;
    logic r_s1_eol;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_emit <= 1'b0;
`ifdef MATRIX_WIN_FLAGS_EN
            r_s1_sof  <= 1'b0;
            r_s1_eol  <= 1'b0;
`endif
        end else if (!w_stall) begin
            r_s1_vld  <= w_accept;
            r_s1_emit <= w_accept & w_emit;
`ifdef MATRIX_WIN_FLAGS_EN
            r_s1_sof  <= w_accept & w_emit & w_sof;
            r_s1_eol  <= w_accept & w_emit & w_eol;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Column shift register and window assembly
    // -------------------------------------------------------------------------
    logic [CV_W-1:0]         w_col_new;   // column of the stage-1 pixel
    logic [CV_W-1:0]         r_sh0;       // previous column
    logic [CV_W-1:0]         r_sh1;       // column before that (oldest)
    logic [9*DATA_WIDTH-1:0] w_win_next;

    // Row index r inside a column sits at [DATA_WIDTH*r +: DATA_WIDTH].
    assign w_col_new = {r_s1_pix, r_lb1_q, r_lb2_q};

    // Pure datapath shift; advances once per accepted pixel leaving stage 1.
    always_ff @(posedge clk) begin
        if (!w_stall && r_s1_vld) begin
            r_sh1 <= r_sh0;
            r_sh0 <= w_col_new;
        end
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_win_next = '0;
        for (int r = 0; r < 3; r++) begin
            w_win_next[DATA_WIDTH*(3*r+0) +: DATA_WIDTH] = r_sh1[DATA_WIDTH*r +: DATA_WIDTH];
            w_win_next[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = r_sh0[DATA_WIDTH*r +: DATA_WIDTH];
            w_win_next[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = w_col_new[DATA_WIDTH*r +: DATA_WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // Window output register
    // -------------------------------------------------------------------------
    logic                    r_win_vld;
    logic [9*DATA_WIDTH-1:0] r_win_data;
`ifdef MATRIX_WIN_FLAGS_EN
    logic                    r_win_sof;
    logic                    r_win_eol;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_vld  <= 1'b0;
            r_win_data <= '0;
`ifdef MATRIX_WIN_FLAGS_EN
            r_win_sof  <= 1'b0;
            r_win_eol  <= 1'b0;
`endif
        end else if (!w_stall) begin
            // A bubble drops win_vld for one cycle; data is only replaced by
            // a new window, so a window is never repeated.
            r_win_vld <= r_s1_emit;
            if (r_s1_emit) begin
                r_win_data <= w_win_next;
            end
`ifdef MATRIX_WIN_FLAGS_EN
            r_win_sof <= r_s1_sof;
            r_win_eol <= r_s1_eol;
`endif
        end
    end

    assign win_vld  = r_win_vld;
    assign win_data = r_win_data;
`ifdef MATRIX_WIN_FLAGS_EN
    assign win_sof  = r_win_sof;
    assign win_eol  = r_win_eol;
`endif

endmodule
